// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
//   Iterative AES encryption controller. Accepts one plaintext block and applies
//   round-0 AddRoundKey. It then drives NR__ROUNDS passes through an external
//   combinational round datapath, and presents the ciphertext on a valid/ready
//   output.
//
// Optional feature macro: AES_SEQ_ABORT_EN (adds the 'abort' input).
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   abort      in   1   (AES_SEQ_ABORT_EN only) drop the block in flight
//   in_valid   in   1   plaintext offered
//   in_ready   out  1   sequencer idle and able to accept
//   in_block   in   W   plaintext
//   rk_idx     out  RW  round-key index to key store
//   rk_word    in   W   round key for rk_idx (same cycle)
//   dp_state   out  W   current state to round datapath
//   dp_last    out  1   final round, datapath skips MixColumns
//   dp_result  in   W   round datapath output
//   out_valid  out  1   ciphertext valid
//   out_ready  in   1   downstream accepts ciphertext
//   out_block  out  W   ciphertext
module aes_round_sequencer #(
   parameter  int unsigned NK__KEY_LENGTH           = 8,
   parameter  int unsigned NR__ROUNDS               = 14,
   parameter  int unsigned NB__BLOCK_LENGTH_IN_TEXT = 4,
   localparam int unsigned W  = NB__BLOCK_LENGTH_IN_TEXT * NK__KEY_LENGTH * 4,
   localparam int unsigned RW = $clog2(NR__ROUNDS + 1)
) (
   input  logic          clk,
   input  logic          rst,
`ifdef AES_SEQ_ABORT_EN
   input  logic          abort,
`endif
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_block,
   output logic [RW-1:0] rk_idx,
   input  logic [W-1:0]  rk_word,
   output logic [W-1:0]  dp_state,
   output logic          dp_last,
   input  logic [W-1:0]  dp_result,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_block
);

   localparam logic [RW-1:0] LAST_ROUND = RW'(NR__ROUNDS);
   localparam logic [RW-1:0] FIRST_ROUND = RW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_DONE  = 2'd2
   } fsm_t;

   fsm_t          r_fsm;
   logic [RW-1:0] r_round;
   logic [W-1:0]  r_state;
   logic          r_in_ready;
   logic          r_out_valid;
   logic [RW-1:0] r_rk_idx;
   logic          r_dp_last;

   fsm_t          w_fsm_nxt;
   logic [RW-1:0] w_round_nxt;
   logic [W-1:0]  w_state_nxt;
   logic          w_in_ready_nxt;
   logic          w_out_valid_nxt;
   logic [RW-1:0] w_rk_idx_nxt;
   logic          w_dp_last_nxt;

   // Next-state and next-output decode; outputs are registered from the next state.
   always_comb begin
      w_fsm_nxt       = r_fsm;
      w_round_nxt     = r_round;
      w_state_nxt     = r_state;
      w_in_ready_nxt  = 1'b0;
      w_out_valid_nxt = 1'b0;
      w_rk_idx_nxt    = '0;
      w_dp_last_nxt   = 1'b0;

      unique case (r_fsm)
         S_IDLE: begin
            // rk_idx is 0 here, so rk_word is the whitening key
            if (in_valid && r_in_ready) begin
               w_state_nxt = in_block ^ rk_word;
               w_round_nxt = FIRST_ROUND;
               w_fsm_nxt   = S_ROUND;
            end
         end
         S_ROUND: begin
            w_state_nxt = dp_result;
            // Round counter saturates at the last round
            if (r_round == LAST_ROUND) begin
               w_fsm_nxt = S_DONE;
            end else begin
               w_round_nxt = r_round + FIRST_ROUND;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_fsm_nxt   = S_IDLE;
               w_round_nxt = '0;
            end
         end
         default: begin
            w_fsm_nxt   = S_IDLE;
            w_round_nxt = '0;
         end
      endcase

`ifdef AES_SEQ_ABORT_EN
      // Abort beats the output handshake; the state register keeps its contents
      if (abort && (r_fsm != S_IDLE)) begin
         w_fsm_nxt   = S_IDLE;
         w_round_nxt = '0;
         w_state_nxt = r_state;
      end
`endif

      if (w_fsm_nxt == S_IDLE) begin
         w_in_ready_nxt = 1'b1;
      end
      if (w_fsm_nxt == S_DONE) begin
         w_out_valid_nxt = 1'b1;
      end
      if (w_fsm_nxt == S_ROUND) begin
         w_rk_idx_nxt  = w_round_nxt;
         w_dp_last_nxt = (w_round_nxt == LAST_ROUND);
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fsm       <= S_IDLE;
         r_round     <= '0;
         r_state     <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_rk_idx    <= '0;
         r_dp_last   <= 1'b0;
      end else begin
         r_fsm       <= w_fsm_nxt;
         r_round     <= w_round_nxt;
         r_state     <= w_state_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_rk_idx    <= w_rk_idx_nxt;
         r_dp_last   <= w_dp_last_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign rk_idx    = r_rk_idx;
   assign dp_last   = r_dp_last;
   assign dp_state  = r_state;
   assign out_block = r_state;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: AES-256 round datapath and key store model,
// a whole-block reference encryptor, directed steps with random plaintexts/keys.
module tb_aes_round_sequencer;

   localparam int NR = 14;
   localparam int W  = 128;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_block;
   logic [RW-1:0] rk_idx;
   logic [W-1:0]  rk_word;
   logic [W-1:0]  dp_state;
   logic          dp_last;
   logic [W-1:0]  dp_result;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_block;
`ifdef AES_SEQ_ABORT_EN
   logic          abort;
`endif

   logic [W-1:0] rk [0:15];
   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   aes_round_sequencer dut (
      .clk       (clk),
      .rst       (rst),
`ifdef AES_SEQ_ABORT_EN
      .abort     (abort),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_block  (in_block),
      .rk_idx    (rk_idx),
      .rk_word   (rk_word),
      .dp_state  (dp_state),
      .dp_last   (dp_last),
      .dp_result (dp_result),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_block (out_block)
   );

   // ---------------- AES arithmetic ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xt(x);
      end
      return p;
   endfunction

   // S-box from the field inverse (a^254) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] y;
      logic [7:0] v;
      y = a;
      v = 8'h01;
      for (int i = 1; i < 8; i++) begin
         y = gmul(y, y);
         v = gmul(v, y);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^
             {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] t);
      return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
   endfunction

   // One AES round; byte i of the block is state row i%4, column i/4
   function automatic logic [W-1:0] aes_round(input logic [W-1:0] s,
                                              input logic [W-1:0] k,
                                              input logic         last);
      logic [7:0]   a [0:15];
      logic [7:0]   b [0:15];
      logic [7:0]   m [0:15];
      logic [W-1:0] o;
      for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++) begin
         if (last) begin
            for (int r = 0; r < 4; r++) m[r+4*c] = b[r+4*c];
         end else begin
            m[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
            m[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
            m[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
            m[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
      return o ^ k;
   endfunction

   // AES-256 key schedule into the round-key store
   task automatic expand_key(input logic [255:0] key);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xt(rc);
         end else if (i % 8 == 4) begin
            t = subword(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r <= NR; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk[15] = '0;
   endtask

   // Whole-block reference: whitening then NR rounds, last one without MixColumns
   function automatic logic [W-1:0] ref_enc(input logic [W-1:0] pt);
      logic [W-1:0] s;
      s = pt ^ rk[0];
      for (int r = 1; r <= NR; r++) s = aes_round(s, rk[r], r == NR);
      return s;
   endfunction

   // Key store and combinational round datapath around the DUT
   assign rk_word   = rk[rk_idx];
   assign dp_result = aes_round(dp_state, rk_word, dp_last);

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_in_ready"},  W'(in_ready),  W'(1'b1));
      chk({tag, "_out_valid"}, W'(out_valid), W'(1'b0));
      chk({tag, "_rk_idx"},    W'(rk_idx),    W'(0));
      chk({tag, "_dp_last"},   W'(dp_last),   W'(1'b0));
   endtask

   // Wait (bounded) for in_ready with in_valid already driven, then take the accepting edge
   task automatic wait_accept(output int waited);
      waited = 0;
      while (!in_ready && waited < 100) begin
         step();
         waited++;
      end
      chk("accept_ready", W'(in_ready), W'(1'b1));
      step();
   endtask

   // Cycle c after the accepting edge: rounds 1..NR in cycles 1..NR, result in cycle NR+1
   task automatic track(input logic [W-1:0] exp_ct, input int stop_c, input bit drop_valid);
      if (drop_valid) in_valid = 1'b0;
      for (int c = 1; c <= stop_c; c++) begin
         if (c <= NR) chk("rk_idx", W'(rk_idx), W'(c));
         chk("dp_last",   W'(dp_last),   W'(c == NR));
         chk("out_valid", W'(out_valid), W'(c == NR + 1));
         chk("in_ready",  W'(in_ready),  W'(1'b0));
         if (c == NR + 1) chk("out_block", out_block, exp_ct);
         if (c < stop_c) step();
      end
   endtask

   function automatic logic [W-1:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]   pt;
      logic [W-1:0]   pt2;
      logic [W-1:0]   ct;
      logic [W-1:0]   pts [0:3];
      logic [255:0]   key;
      int             waited;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_block  = '0;
      out_ready = 1'b0;
`ifdef AES_SEQ_ABORT_EN
      abort     = 1'b0;
`endif
      expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

      // Reset
      step();
      step();
      rst = 1'b0;
      chk_idle("reset");
      chk("reset_out_block", out_block, '0);

      // FIPS-197 C.3 vector
      pt = 128'h00112233445566778899aabbccddeeff;
      chk("fips_model", ref_enc(pt), 128'h8ea2b7ca516745bfeafc49904b496089);
      in_valid  = 1'b1;
      in_block  = pt;
      out_ready = 1'b1;
      wait_accept(waited);
      chk("fips_wait", W'(waited), W'(0));
      track(128'h8ea2b7ca516745bfeafc49904b496089, NR + 1, 1'b1);
      step();
      chk_idle("fips_done");

      // Backpressure: 20 cycles held in DONE while another block is offered
      pt = rnd128();
      ct = ref_enc(pt);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_block  = pt;
      wait_accept(waited);
      track(ct, NR + 1, 1'b1);
      pt2      = rnd128();
      in_valid = 1'b1;
      in_block = pt2;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("bp_out_valid", W'(out_valid), W'(1'b1));
         chk("bp_out_block", out_block, ct);
         chk("bp_in_ready",  W'(in_ready),  W'(1'b0));
      end
      out_ready = 1'b1;
      step();
      chk_idle("bp_release");
      wait_accept(waited);
      chk("bp_held_wait", W'(waited), W'(0));
      track(ref_enc(pt2), NR + 1, 1'b1);
      step();
      chk_idle("bp_held_done");

      // Back-to-back with a random key: one accept every NR+2 cycles
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key);
      for (int i = 0; i < 4; i++) pts[i] = rnd128();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_block = pts[i];
         wait_accept(waited);
         chk("b2b_wait", W'(waited), W'(0));
         track(ref_enc(pts[i]), NR + 1, 1'b0);
         step();
         chk("b2b_idle_in_ready",  W'(in_ready),  W'(1'b1));
         chk("b2b_idle_out_valid", W'(out_valid), W'(1'b0));
      end
      in_valid = 1'b0;

      // Reset at round 7 discards the block
      pt = rnd128();
      in_valid = 1'b1;
      in_block = pt;
      wait_accept(waited);
      track(ref_enc(pt), 7, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("midrst");
      chk("midrst_out_block", out_block, '0);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("midrst_no_out", W'(out_valid), W'(1'b0));
      end
      pt = rnd128();
      in_valid = 1'b1;
      in_block = pt;
      wait_accept(waited);
      track(ref_enc(pt), NR + 1, 1'b1);
      step();
      chk_idle("midrst_next_done");

`ifdef AES_SEQ_ABORT_EN
      // Abort at round 5
      pt = rnd128();
      in_valid = 1'b1;
      in_block = pt;
      wait_accept(waited);
      track(ref_enc(pt), 5, 1'b1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk_idle("abort_round");
      for (int i = 0; i < 20; i++) begin
         step();
         chk("abort_no_out", W'(out_valid), W'(1'b0));
      end

      // Abort in DONE wins over out_ready
      pt = rnd128();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_block  = pt;
      wait_accept(waited);
      track(ref_enc(pt), NR + 1, 1'b1);
      out_ready = 1'b1;
      abort     = 1'b1;
      step();
      abort = 1'b0;
      chk_idle("abort_done");

      // Abort while idle does not block acceptance
      pt = rnd128();
      in_valid = 1'b1;
      in_block = pt;
      abort    = 1'b1;
      wait_accept(waited);
      abort = 1'b0;
      chk("abort_idle_wait", W'(waited), W'(0));
      track(ref_enc(pt), NR + 1, 1'b1);
      step();
      chk_idle("abort_idle_done");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
